uart_disp_ctrl: RTL and testbench



---
 rtl/uart_disp_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_disp_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_disp_ctrl.sv
// UART command controller for the 6-digit rotating seven-segment display.
// Define DISP_BLINK_EN to add the 'B' blink command; without it 'B' is rejected.
module uart_disp_ctrl #(
    parameter int TURNS        = 25_000_000,
    parameter int TIMEOUT      = 50_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [4:0] in0,
    output logic [4:0] in1,
    output logic [4:0] in2,
    output logic [4:0] in3,
    output logic [4:0] in4,
    output logic [4:0] in5,
    output logic       rotating,
    output logic       resp_drop
);

    localparam int TURN_W = (TURNS > 1) ? $clog2(TURNS) : 1;
    localparam int TOUT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNS - 1);
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT - 1);
    localparam logic [7:0] ACK_K = 8'h4B;
    localparam logic [7:0] ACK_E = 8'h45;
    localparam logic [4:0] BLANK = 5'h1F;

    typedef enum logic [1:0] {IDLE, GET_IDX, GET_VAL} state_t;

    state_t            state, state_next;
    logic [2:0]        idx;
    logic [4:0]        dig [6];
    logic [4:0]        disp [6];
    logic [TURN_W-1:0] rot_cnt;
    logic [TOUT_W-1:0] tout_cnt;
    logic              tick;
    logic              blank;
    logic [5:0]        dec;

    logic              ack_req;
    logic [7:0]        ack_byte;
    logic              idx_load;
    logic              wr_en;
    logic              set_rot;
    logic              clr_rot;
    logic              clr_all;
`ifdef DISP_BLINK_EN
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
    logic               blink_tgl;
    logic               blink_on;
    logic               blink_phase;
    logic [BLINK_W-1:0] blink_cnt;
`endif

    // Value byte decode: {accepted, digit code}; '_' selects the blank code.
    function automatic logic [5:0] decode_val(input logic [7:0] b);
        logic [5:0] r;
        r = 6'd0;
        if (b >= 8'h30 && b <= 8'h39)      r = {2'b10, 4'(b - 8'h30)};
        else if (b >= 8'h41 && b <= 8'h46) r = {2'b10, 4'(b - 8'h37)};
        else if (b >= 8'h61 && b <= 8'h66) r = {2'b10, 4'(b - 8'h57)};
        else if (b == 8'h5F)               r = {1'b1, BLANK};
        return r;
    endfunction

    assign dec  = decode_val(rx_data);
    assign tick = rotating && (rot_cnt == TURN_LAST);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        ack_req    = 1'b0;
        ack_byte   = ACK_K;
        idx_load   = 1'b0;
        wr_en      = 1'b0;
        set_rot    = 1'b0;
        clr_rot    = 1'b0;
        clr_all    = 1'b0;
`ifdef DISP_BLINK_EN
        blink_tgl  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    ack_req = 1'b1;
                    case (rx_data)
                        8'h44: begin state_next = GET_IDX; ack_req = 1'b0; end
                        8'h52: set_rot = 1'b1;
                        8'h53: clr_rot = 1'b1;
                        8'h43: clr_all = 1'b1;
`ifdef DISP_BLINK_EN
                        8'h42: blink_tgl = 1'b1;
`endif
                        default: ack_byte = ACK_E;
                    endcase
                end
            end
            GET_IDX: begin
                if (rx_valid) begin
                    if (rx_data >= 8'h30 && rx_data <= 8'h35) begin
                        idx_load   = 1'b1;
                        state_next = GET_VAL;
                    end else begin
                        ack_req    = 1'b1;
                        ack_byte   = ACK_E;
                        state_next = IDLE;
                    end
                end else if (tout_cnt == TOUT_LAST) begin
                    ack_req    = 1'b1;
                    ack_byte   = ACK_E;
                    state_next = IDLE;
                end
            end
            GET_VAL: begin
                state_next = IDLE;
                if (rx_valid) begin
                    ack_req  = 1'b1;
                    wr_en    = dec[5];
                    ack_byte = dec[5] ? ACK_K : ACK_E;
                end else if (tout_cnt == TOUT_LAST) begin
                    ack_req  = 1'b1;
                    ack_byte = ACK_E;
                end else begin
                    state_next = GET_VAL;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 3'd0;
            tout_cnt <= '0;
        end else begin
            state    <= state_next;
            tout_cnt <= (rx_valid || state_next == IDLE) ? '0 : tout_cnt + 1'b1;
            if (idx_load) idx <= rx_data[2:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rotating <= 1'b0;
            rot_cnt  <= '0;
        end else begin
            rot_cnt <= (!rotating || tick) ? '0 : rot_cnt + 1'b1;
            if (clr_all || clr_rot) rotating <= 1'b0;
            else if (set_rot)       rotating <= 1'b1;
        end
    end

    // NOTE: the digit array is reset explicitly because its power-up value (blank) is visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 6; k++) dig[k] <= BLANK;
        end else if (clr_all) begin
            for (int k = 0; k < 6; k++) dig[k] <= BLANK;
        end else begin
            if (tick) begin
                dig[0] <= dig[5];
                for (int k = 1; k < 6; k++) dig[k] <= dig[k-1];
            end
            // A write issued with a rotation step lands last and overrides the rotated value.
            if (wr_en) dig[idx] <= dec[4:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            resp_drop <= 1'b0;
        end else begin
            if (clr_all) resp_drop <= 1'b0;
            if (ack_req) begin
                if (tx_valid && !tx_ready) begin
                    resp_drop <= 1'b1;
                end else begin
                    tx_data  <= ack_byte;
                    tx_valid <= 1'b1;
                end
            end else if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
            end
        end
    end

`ifdef DISP_BLINK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_on    <= 1'b0;
            blink_phase <= 1'b0;
            blink_cnt   <= '0;
        end else if (clr_all) begin
            blink_on    <= 1'b0;
            blink_phase <= 1'b0;
            blink_cnt   <= '0;
        end else begin
            if (blink_tgl) blink_on <= !blink_on;
            if (!blink_on) begin
                blink_phase <= 1'b0;
                blink_cnt   <= '0;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_phase <= !blink_phase;
                blink_cnt   <= '0;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign blank = blink_phase;
`else
    logic unused_blink;
    assign unused_blink = (BLINK_CYCLES > 0);
    assign blank = 1'b0;
`endif

    always_comb begin
        for (int k = 0; k < 6; k++) disp[k] = blank ? BLANK : dig[k];
    end

    assign in0 = disp[0];
    assign in1 = disp[1];
    assign in2 = disp[2];
    assign in3 = disp[3];
    assign in4 = disp[4];
    assign in5 = disp[5];

endmodule

// File: tb/tb_uart_disp_ctrl.sv
// Self-checking bench for uart_disp_ctrl: directed scenarios plus random byte
// streams compared every cycle against a command-level reference model.
module tb_uart_disp_ctrl;

    localparam int TURNS   = 4;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [4:0] in0, in1, in2, in3, in4, in5;
    logic       rotating;
    logic       resp_drop;

    uart_disp_ctrl #(.TURNS(TURNS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
        .rotating(rotating), .resp_drop(resp_drop)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: display contents, pending command bytes, ack slot.
    logic [4:0] m_dig [6];
    bit         m_rot, m_drop, m_tv;
    logic [7:0] m_td;
    int         m_pend, m_idx, m_wait, m_age;

    task automatic model_reset();
        for (int k = 0; k < 6; k++) m_dig[k] = 5'h1F;
        m_rot = 0; m_drop = 0; m_tv = 0; m_td = 8'h00;
        m_pend = 0; m_idx = 0; m_wait = 0; m_age = 0;
    endtask

    task automatic model_step();
        logic [4:0] nd [6];
        bit         hs, ack, tick, clr, new_rot;
        logic [7:0] ab;
        int         b;
        hs   = m_tv && tx_ready;
        ack  = 0; ab = 8'h4B; clr = 0;
        tick = m_rot && (m_age % TURNS == TURNS - 1);
        for (int k = 0; k < 6; k++) nd[k] = tick ? m_dig[(k + 5) % 6] : m_dig[k];
        new_rot = m_rot;
        if (rx_valid) begin
            b = int'(rx_data);
            m_wait = 0;
            if (m_pend == 0) begin
                ack = 1;
                case (b)
                    'h44: begin m_pend = 1; ack = 0; end
                    'h52: new_rot = 1;
                    'h53: new_rot = 0;
                    'h43: clr = 1;
                    default: ab = 8'h45;
                endcase
            end else if (m_pend == 1) begin
                if (b >= 'h30 && b <= 'h35) begin
                    m_idx = b - 'h30; m_pend = 2;
                end else begin
                    ack = 1; ab = 8'h45; m_pend = 0;
                end
            end else begin
                ack = 1; m_pend = 0;
                if (b >= 'h30 && b <= 'h39)      nd[m_idx] = 5'(b - 'h30);
                else if (b >= 'h41 && b <= 'h46) nd[m_idx] = 5'(b - 'h41 + 10);
                else if (b >= 'h61 && b <= 'h66) nd[m_idx] = 5'(b - 'h61 + 10);
                else if (b == 'h5F)              nd[m_idx] = 5'h1F;
                else                             ab = 8'h45;
            end
        end else if (m_pend != 0) begin
            if (m_wait == TIMEOUT - 1) begin
                m_pend = 0; m_wait = 0; ack = 1; ab = 8'h45;
            end else begin
                m_wait++;
            end
        end
        if (clr) begin
            for (int k = 0; k < 6; k++) nd[k] = 5'h1F;
            new_rot = 0;
            m_drop  = 0;
        end
        m_age = m_rot ? m_age + 1 : 0;
        m_rot = new_rot;
        for (int k = 0; k < 6; k++) m_dig[k] = nd[k];
        if (ack) begin
            if (m_tv && !hs) m_drop = 1;
            else begin m_td = ab; m_tv = 1; end
        end else if (hs) begin
            m_tv = 0;
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return 64'({in5, in4, in3, in2, in1, in0, rotating, resp_drop, tx_valid, tx_data});
    endfunction

    function automatic logic [63:0] model_vec();
        return 64'({m_dig[5], m_dig[4], m_dig[3], m_dig[2], m_dig[1], m_dig[0],
                    m_rot, m_drop, m_tv, m_td});
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("outputs", dut_vec(), model_vec());
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        cycle();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        logic [63:0] rst_vec;
        rst_vec  = 64'({{6{5'h1F}}, 3'b000, 8'h00});
        rx_valid = 1'b0;
        rst      = 1'b1;
        #2;
        model_reset();
        check("reset_state", dut_vec(), rst_vec);
        rst = 1'b0;
    endtask

    initial begin
        string picks;
        int    r;
        picks    = "DDDDRSC0123456789AaFf__x7B/";
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single digit write, one-cycle ack.
        send(8'h44); send(8'h33); send(8'h41);
        check("t1_in3", 64'(in3), 64'h0A);
        check("t1_in0", 64'(in0), 64'h1F);
        check("t1_ack", 64'({tx_valid, tx_data}), 64'h14B);
        cycle();
        check("t1_ack_gone", 64'(tx_valid), 64'h0);

        // Bad index, then blank write.
        send(8'h44); send(8'h37);
        check("t2_bad_idx", 64'({tx_valid, tx_data}), 64'h145);
        send(8'h44); send(8'h30); send(8'h5F);
        check("t2_blank", 64'({in0, tx_valid, tx_data}), 64'({5'h1F, 9'h14B}));
        idle(2);

        // Rotation: load 1..6, run, stop.
        for (int k = 0; k < 6; k++) begin
            send(8'h44); send(8'(8'h30 + k)); send(8'(8'h31 + k));
        end
        check("rot_loaded", 64'({in5, in4, in3, in2, in1, in0}),
              64'({5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}));
        send(8'h52);
        idle(4);
        check("rot_step1", 64'({in5, in4, in3, in2, in1, in0}),
              64'({5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd6}));
        idle(20);
        check("rot_full", 64'({in5, in4, in3, in2, in1, in0}),
              64'({5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}));
        send(8'h53);
        idle(10);
        check("rot_frozen", 64'({rotating, in5, in4, in3, in2, in1, in0}),
              64'({1'b0, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}));

        // Timeout after a lone 'D'; the next byte is a fresh command.
        send(8'h44);
        idle(7);
        check("tout_early", 64'(tx_valid), 64'h0);
        cycle();
        check("tout_ack", 64'({tx_valid, tx_data}), 64'h145);
        send(8'h78);
        check("tout_next", 64'({tx_valid, tx_data}), 64'h145);
        idle(2);

        // Response drop under back-pressure.
        tx_ready = 1'b0;
        send(8'h52);
        send(8'h53);
        check("drop_state", 64'({tx_data, resp_drop, rotating}), 64'({8'h4B, 1'b1, 1'b0}));
        tx_ready = 1'b1;
        cycle();
        check("drop_hs", 64'(tx_valid), 64'h0);
        send(8'h43);
        check("drop_clear", 64'(resp_drop), 64'h0);
        idle(2);

        // Reset mid-command discards the partial command.
        send(8'h44); send(8'h32);
        do_reset();
        send(8'h35);
        check("rst_cmd_lost", 64'({tx_valid, tx_data}), 64'h145);

        // Random byte streams with random back-pressure.
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 999);
            tx_ready = ($urandom_range(0, 3) != 0);
            if (r < 3) begin
                do_reset();
            end else if (r < 300) begin
                if ($urandom_range(0, 9) == 0) send(8'($urandom_range(0, 255)));
                else send(picks[$urandom_range(0, picks.len() - 1)]);
            end else if (r < 320) begin
                idle($urandom_range(6, 12));
            end else begin
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
